// File: rtl/img_lk_pkg.sv
// img_lk_pkg: shared Lucas-Kanade types and default widths for the accumulator and solver
package img_lk_pkg;
  localparam int LK_SOBEL_BITS = 12;
  localparam int LK_ACC_BITS = 48;
  localparam int LK_X_BITS = 12;
  localparam int LK_Y_BITS = 12;
  typedef logic signed [LK_SOBEL_BITS-1:0] sobel_t;
  typedef logic signed [LK_ACC_BITS-1:0] acc_t;
  typedef struct packed {
    acc_t xx;
    acc_t yy;
    acc_t xy;
    acc_t xt;
    acc_t yt;
  } lk_sum_t;
endpackage

// File: rtl/img_lk_roi_counter.sv
// img_lk_roi_counter: pixel x/y tracking, frame-start ROI latch, registered start/end/hit flags
module img_lk_roi_counter import img_lk_pkg::*; #(
  parameter int X_BITS = LK_X_BITS,
  parameter int Y_BITS = LK_Y_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cke,
  input  logic              de,
  input  logic              row_first,
  input  logic              row_last,
  input  logic              col_first,
  input  logic              col_last,
  input  logic [X_BITS-1:0] roi_x,
  input  logic [X_BITS-1:0] roi_w,
  input  logic [Y_BITS-1:0] roi_y,
  input  logic [Y_BITS-1:0] roi_h,
  output logic              s0_start,
  output logic              s0_end,
  output logic              s0_hit
);
  logic [X_BITS-1:0] x_q, rx_q, rw_q, x_c, rx_c, rw_c;
  logic [Y_BITS-1:0] y_q, ry_q, rh_q, y_c, ry_c, rh_c;
  logic start, hit;
  // the start pixel sees the fresh ROI so it can be tested against it in the same cycle
  always_comb begin
    start = de & row_first & col_first;
    x_c = col_first ? '0 : x_q + X_BITS'(1);
    y_c = start ? '0 : col_first ? y_q + Y_BITS'(1) : y_q;
    rx_c = start ? roi_x : rx_q;
    rw_c = start ? roi_w : rw_q;
    ry_c = start ? roi_y : ry_q;
    rh_c = start ? roi_h : rh_q;
    hit = ({1'b0, x_c} >= {1'b0, rx_c}) && ({1'b0, x_c} < {1'b0, rx_c} + {1'b0, rw_c}) &&
          ({1'b0, y_c} >= {1'b0, ry_c}) && ({1'b0, y_c} < {1'b0, ry_c} + {1'b0, rh_c});
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
      rx_q <= '0;
      rw_q <= '0;
      ry_q <= '0;
      rh_q <= '0;
      s0_start <= 1'b0;
      s0_end <= 1'b0;
      s0_hit <= 1'b0;
    end else if (cke) begin
      s0_start <= start;
      s0_end <= de & row_last & col_last;
      s0_hit <= de & hit;
      rx_q <= rx_c;
      rw_q <= rw_c;
      ry_q <= ry_c;
      rh_q <= rh_c;
      if (de) begin
        x_q <= x_c;
        y_q <= y_c;
      end
    end
  end
endmodule

// File: rtl/img_lk_accumulator.sv
// img_lk_accumulator: ROI sums of the five LK structure-tensor products, published once per frame
module img_lk_accumulator import img_lk_pkg::*; #(
  parameter int SOBEL_BITS = LK_SOBEL_BITS,
  parameter int ACC_BITS = LK_ACC_BITS,
  parameter int X_BITS = LK_X_BITS,
  parameter int Y_BITS = LK_Y_BITS
) (
  input  logic                         reset,
  input  logic                         clk,
  input  logic                         cke,
  input  logic                         s_img_row_first,
  input  logic                         s_img_row_last,
  input  logic                         s_img_col_first,
  input  logic                         s_img_col_last,
  input  logic                         s_img_de,
  input  logic signed [SOBEL_BITS-1:0] s_diff,
  input  logic signed [SOBEL_BITS-1:0] s_gradx,
  input  logic signed [SOBEL_BITS-1:0] s_grady,
  input  logic [X_BITS-1:0]            param_roi_x,
  input  logic [X_BITS-1:0]            param_roi_w,
  input  logic [Y_BITS-1:0]            param_roi_y,
  input  logic [Y_BITS-1:0]            param_roi_h,
  output logic                         m_valid,
  output logic signed [ACC_BITS-1:0]   m_sum_xx,
  output logic signed [ACC_BITS-1:0]   m_sum_yy,
  output logic signed [ACC_BITS-1:0]   m_sum_xy,
  output logic signed [ACC_BITS-1:0]   m_sum_xt,
  output logic signed [ACC_BITS-1:0]   m_sum_yt,
  output logic [31:0]                  m_count
);
  logic s0_start, s0_end, s0_hit, s1_start, s1_end, s1_hit, in_frame, s2_pub;
  logic signed [SOBEL_BITS-1:0] s0_diff, s0_gx, s0_gy;
  logic signed [2*SOBEL_BITS-1:0] mul [5];
  logic signed [ACC_BITS-1:0] p [5];
  logic signed [ACC_BITS-1:0] acc [5];
  logic signed [ACC_BITS-1:0] sum [5];
  logic [31:0] cnt;
  img_lk_roi_counter #(.X_BITS(X_BITS), .Y_BITS(Y_BITS)) u_roi (
    .clk(clk), .reset(reset), .cke(cke), .de(s_img_de),
    .row_first(s_img_row_first), .row_last(s_img_row_last),
    .col_first(s_img_col_first), .col_last(s_img_col_last),
    .roi_x(param_roi_x), .roi_w(param_roi_w), .roi_y(param_roi_y), .roi_h(param_roi_h),
    .s0_start(s0_start), .s0_end(s0_end), .s0_hit(s0_hit)
  );
  always_ff @(posedge clk) begin
    if (cke) begin
      s0_diff <= s_diff;
      s0_gx <= s_gradx;
      s0_gy <= s_grady;
    end
  end
  always_comb begin
    mul[0] = s0_gx * s0_gx;
    mul[1] = s0_gy * s0_gy;
    mul[2] = s0_gx * s0_gy;
    mul[3] = s0_gx * s0_diff;
    mul[4] = s0_gy * s0_diff;
  end
  // out-of-ROI and idle cycles contribute zero, so the accumulators can add every enabled cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_start <= 1'b0;
      s1_end <= 1'b0;
      s1_hit <= 1'b0;
      in_frame <= 1'b0;
      s2_pub <= 1'b0;
      m_valid <= 1'b0;
      cnt <= '0;
      m_count <= '0;
      for (int k = 0; k < 5; k++) begin
        p[k] <= '0;
        acc[k] <= '0;
        sum[k] <= '0;
      end
    end else if (cke) begin
      s1_start <= s0_start;
      s1_end <= s0_end;
      s1_hit <= s0_hit;
      for (int k = 0; k < 5; k++) begin
        p[k] <= s0_hit ? ACC_BITS'(mul[k]) : '0;
        acc[k] <= (s1_start ? '0 : acc[k]) + p[k];
      end
      cnt <= (s1_start ? '0 : cnt) + 32'(s1_hit);
      in_frame <= !s1_end & (s1_start | in_frame);
      s2_pub <= s1_end & (s1_start | in_frame);
      m_valid <= s2_pub;
      if (s2_pub) begin
        sum <= acc;
        m_count <= cnt;
      end
    end
  end
  assign m_sum_xx = sum[0];
  assign m_sum_yy = sum[1];
  assign m_sum_xy = sum[2];
  assign m_sum_xt = sum[3];
  assign m_sum_yt = sum[4];
endmodule

// File: doc/img_lk_accumulator.md
# img_lk_accumulator

Downstream consumer of the Lucas-Kanade Sobel stage: takes the per-pixel temporal difference and x/y gradients, forms the five LK structure-tensor products, and sums them over a rectangular ROI of each frame. At the last pixel of a frame it publishes the five sums plus the pixel count with a one-cycle valid pulse, for the flow solver (2×2 inverse) that follows.

## Interface

Parameters:
- SOBEL_BITS, 12, width of the signed gradient and diff inputs; `sobel_t` = signed [SOBEL_BITS-1:0]
- ACC_BITS, 48, width of each signed accumulator; `acc_t` = signed [ACC_BITS-1:0]
- X_BITS, 12, width of the column counter and ROI x fields
- Y_BITS, 12, width of the row counter and ROI y fields

Ports:
- reset  in  1  synchronous, active-high
- clk  in  1  single clock; all logic on posedge
- cke  in  1  clock enable; state advances only when 1
- s_img_row_first / s_img_row_last / s_img_col_first / s_img_col_last  in  1 each  frame position flags, qualified by s_img_de
- s_img_de  in  1  data-enable, pixel present this cycle
- s_diff / s_gradx / s_grady  in  SOBEL_BITS  It, Ix, Iy (signed)
- param_roi_x / param_roi_w  in  X_BITS  ROI left column, ROI width
- param_roi_y / param_roi_h  in  Y_BITS  ROI top row, ROI height
- m_valid  out  1  one-cke-cycle pulse, sums valid
- m_sum_xx / m_sum_yy / m_sum_xy / m_sum_xt / m_sum_yt  out  ACC_BITS  ΣIx², ΣIy², ΣIxIy, ΣIxIt, ΣIyIt
- m_count  out  32  number of accumulated pixels

## Operation

- Coordinates: x=0 at col_first, increments per de pixel; y=0 at row_first&col_first, increments at each col_first thereafter.
- ROI params latched at frame start (de & row_first & col_first); changes mid-frame have no effect.
- Pixel in ROI iff roi_x ≤ x < roi_x+roi_w and roi_y ≤ y < roi_y+roi_h (unsigned, X_BITS+1 / Y_BITS+1 compare, no wrap). roi_w=0 or roi_h=0 → count 0, all sums 0.
- Products: full 2·SOBEL_BITS signed, sign-extended to ACC_BITS; accumulation wraps two's-complement (no saturation); ACC_BITS=48 is sufficient for 2^24 pixels at SOBEL_BITS=12.
- State: in_frame flag. IDLE→ACTIVE at frame start; ACTIVE→IDLE on frame-end pixel (de & row_last & col_last), which publishes results.
- Frame start pixel loads accumulators (product or 0 if not in ROI) rather than adding — no separate clear cycle.
- Frame start while ACTIVE (aborted frame): previous partial sums discarded, no m_valid, restart.
- Frame end while IDLE (e.g. first partial frame after reset): ignored, no m_valid.
- Single-pixel frame (all four flags together): start and end in same pixel; publishes that pixel.
- Outputs m_sum_*/m_count hold last published values until next publish.

## Timing

- Pipeline, each stage gated by cke: S0 register inputs, flags, x/y, ROI hit; S1 five multiplies; S2 accumulate; S3 output registers + m_valid.
- Latency: frame-end pixel accepted at cke-cycle N → m_valid=1 at cke-cycle N+3 (3 enabled cycles); deasserts on next enabled cycle. With cke=0, m_valid and all regs hold.
- Throughput: one pixel per enabled cycle; back-to-back frames (start immediately after end) supported, no bubble.
- Reset: m_valid=0, all m_sum_*=0, m_count=0, in_frame=0, pipeline flags cleared (in-flight pixels dropped). Reset mid-frame: no publish for that frame.

## Structure

- Shared package `img_lk_pkg`: `sobel_t`, `acc_t`, the five-field packed struct `lk_sum_t` (xx, yy, xy, xt, yt), reused by the solver.
- One natural sub-module: `img_lk_roi_counter` (x/y counters, ROI latch, hit/start/end flags, aligned with S0). Multipliers inferred inline (DSP).

## Test plan

- 4×4 frame, ROI 0,0,4,4, gx=1, gy=2, diff=-1 all pixels → m_valid 3 cycles after last pixel; xx=16, yy=64, xy=32, xt=-16, yt=-32, count=16.
- 8×8 frame, ROI x=2,y=3,w=3,h=2, gx=3 elsewhere 0 → xx=54, count=6; ROI params changed mid-frame do not alter result.
- Extreme values gx=gy=-2048, diff=2047 on 4 pixels → xx=yy=xy=16777216, xt=yt=-16769024; correct sign extension.
- Aborted frame: second frame start before first frame end → no m_valid for first; second frame publishes only its own sums.
- cke toggled randomly with 50% duty over a 4×4 frame → results identical to cke=1; m_valid pulse length one enabled cycle.
- Reset asserted mid-frame then a complete frame → outputs 0 after reset, single m_valid for the complete frame only; frame-end without start after reset produces no m_valid.
